piso_stream: RTL and testbench
==============================

Name: piso_stream

Overview:
- Parametrised parallel-in/serial-out word serializer with valid/ready handshake.
- Captures NUM_WORDS words of DATA_WIDTH bits in one load, then emits them one word per accepted beat, word 0 first.
- Supports one-shot mode and repeat mode. Repeat mode rotates continuously through the captured words until the next load.
- Sits between multi-word producers (register-file read ports, pipeline result buses) and single-word consumers (bus writers, debug/trace ports).

Parameters:
- DATA_WIDTH, 32, width of one word.
- NUM_WORDS, 3, words captured per load; legal range 2..256.
- IDX_WIDTH, derived localparam = $clog2(NUM_WORDS); not overridable.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  synchronous active-high reset.
- i_load  input  1  load request; accepted only when o_load_ready=1.
- i_repeat  input  1  mode, sampled with an accepted load: 1 = repeat, 0 = one-shot.
- i_data  input  DATA_WIDTH*NUM_WORDS  packed words; word k = i_data[k*DATA_WIDTH +: DATA_WIDTH].
- o_load_ready  output  1  block can accept a load this cycle.
- o_valid  output  1  o_data holds a valid word.
- i_ready  input  1  consumer accepts the word; a beat occurs when o_valid & i_ready.
- o_data  output  DATA_WIDTH  current word.
- o_index  output  IDX_WIDTH  index of the current word.
- o_last  output  1  o_valid & (o_index == NUM_WORDS-1).

Behaviour:
- Reset (i_rst=1 at clock edge):
  - o_valid=0, o_index=0, repeat flag=0, all word registers=0, o_data=0, o_last=0.
  - Reset has priority over load and beat, including mid-sequence; the sequence is discarded.
- Output paths:
  - o_data and o_last are combinational from registered state only; no combinational path from i_data/i_load.
  - o_load_ready may depend combinationally on i_ready.
- Load acceptance:
  - o_load_ready = ~o_valid | repeat_q | (o_valid & i_ready & o_last).
  - On an accepted load, at the next edge: all NUM_WORDS words registered, o_index=0, o_valid=1, repeat_q=i_repeat.
  - Latency from load to first valid word is exactly 1 cycle.
- Priority: an accepted load overrides a simultaneous beat.
  - In one-shot mode, a load coincident with the final beat chains seamlessly. The last word is consumed and word 0 of the new set appears next cycle with no bubble.
  - In repeat mode a load preempts the rotation at any index; the current beat, if any, completes as consumed.
- Beat without load:
  - o_index < NUM_WORDS-1: o_index increments.
  - o_index == NUM_WORDS-1, repeat_q=1: o_index wraps to 0 and o_valid stays 1.
  - o_index == NUM_WORDS-1, repeat_q=0: o_valid clears to 0, o_index returns to 0, and the block is idle.
- No beat (o_valid & ~i_ready): o_index, o_data and the word registers hold. o_data must stay stable while stalled.
- Ignored input:
  - i_load while o_load_ready=0 is ignored; no capture, no error flag.
  - The producer must hold its request until accepted.
- Idle: o_valid=0, o_data=word registers[0] (stale), o_last=0. i_ready is ignored while o_valid=0.
- State summary: IDLE (o_valid=0) and SEND (o_valid=1, index 0..NUM_WORDS-1, repeat_q). There are no other states.
- Index arithmetic:
  - The index compare uses NUM_WORDS-1 explicitly, never a power-of-two wrap.
  - For non-power-of-two NUM_WORDS, index values >= NUM_WORDS are unreachable.

Test Plan:
- One-shot, i_ready tied 1, NUM_WORDS=3: load {C,B,A}={0x33,0x22,0x11} -> one cycle later o_data 0x11,0x22,0x33 on consecutive cycles, o_index 0,1,2, o_last only on 0x33, then o_valid=0.
- Backpressure: same load, i_ready=0 for 4 cycles after word 1 appears -> o_data holds 0x22 and o_index=1 for all 4 cycles; o_load_ready=0 throughout; sequence resumes with 0x33.
- Back-to-back: second load {0x66,0x55,0x44} asserted in the cycle word 0x33 is accepted -> output 0x11,0x22,0x33,0x44,0x55,0x66 with o_valid continuously 1.
- Repeat: load with i_repeat=1, i_ready=1 -> 0x11,0x22,0x33,0x11,0x22... for 10 cycles. A new load while showing 0x22 gives 0x44 as the next word; o_load_ready stays 1 throughout.
- Reset mid-sequence: i_rst while o_index=1 -> next cycle o_valid=0, o_index=0, o_data=0. A load one cycle after reset starts cleanly at word 0.
- Ignored load: i_load pulse with data 0x99.. while stalled at index 1 in one-shot mode -> no capture; original words continue unchanged.

Source files
------------

// File: rtl/piso_stream_if.sv
// -----------------------------------------------------------------------------
// piso_stream_if
// Handshake/bus bundle for the piso_stream word serializer.
//
// Signals (names are from the serializer's point of view):
//   i_load       load request from the producer
//   i_repeat     mode sampled with an accepted load (1 = repeat, 0 = one-shot)
//   i_data       NUM_WORDS packed words, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_load_ready serializer can accept a load this cycle
//   o_valid      o_data holds a valid word
//   i_ready      consumer accepts the current word
//   o_data       current word
//   o_index      index of the current word
//   o_last       current word is the final word of the set
//
// Modports:
//   slave  - the serializer itself
//   master - the producer/consumer side driving loads and ready
// -----------------------------------------------------------------------------
interface piso_stream_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 3
) ();
    localparam int IDX_WIDTH = $clog2(NUM_WORDS);

    logic                            i_load;
    logic                            i_repeat;
    logic [DATA_WIDTH*NUM_WORDS-1:0] i_data;
    logic                            o_load_ready;
    logic                            o_valid;
    logic                            i_ready;
    logic [DATA_WIDTH-1:0]           o_data;
    logic [IDX_WIDTH-1:0]            o_index;
    logic                            o_last;

    modport slave (
        input  i_load,
        input  i_repeat,
        input  i_data,
        input  i_ready,
        output o_load_ready,
        output o_valid,
        output o_data,
        output o_index,
        output o_last
    );

    modport master (
        output i_load,
        output i_repeat,
        output i_data,
        output i_ready,
        input  o_load_ready,
        input  o_valid,
        input  o_data,
        input  o_index,
        input  o_last
    );
endinterface

// File: rtl/piso_stream.sv
// -----------------------------------------------------------------------------
// piso_stream
// Parallel-in/serial-out word serializer. One accepted load captures
// NUM_WORDS words; they are then emitted one per accepted beat, word 0 first.
// One-shot mode returns to idle after the last word; repeat mode rotates
// through the captured words until the next load.
//
// Ports:
//   i_clk  clock, all logic on the rising edge
//   i_rst  synchronous active-high reset
//   bus    piso_stream_if slave modport (load, data, valid/ready stream)
// -----------------------------------------------------------------------------
module piso_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    piso_stream_if.slave  bus
);
    localparam int IDX_WIDTH = $clog2(NUM_WORDS);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_WORDS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                 state_q;
    logic [IDX_WIDTH-1:0]   index_q;
    logic                   repeat_q;
    logic [DATA_WIDTH-1:0]  words_q [NUM_WORDS];

    logic valid;
    logic last;
    logic beat;
    logic load_acc;

    assign valid    = (state_q == ST_SEND);
    // Explicit compare against NUM_WORDS-1 so non-power-of-two sizes wrap correctly.
    assign last     = valid & (index_q == LAST_IDX);
    assign beat     = valid & bus.i_ready;
    // A load is also taken on the final beat of a one-shot set, which lets
    // consecutive sets chain without a bubble.
    assign bus.o_load_ready = ~valid | repeat_q | (beat & last);
    assign load_acc = bus.i_load & bus.o_load_ready;

    assign bus.o_valid = valid;
    assign bus.o_index = index_q;
    assign bus.o_last  = last;
    // Index is held at 0 while idle, so idle output shows the stale word 0.
    assign bus.o_data  = words_q[index_q];

    // Sequencing state: a load takes priority over any coincident beat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            index_q  <= '0;
            repeat_q <= 1'b0;
        end else if (load_acc) begin
            state_q  <= ST_SEND;
            index_q  <= '0;
            repeat_q <= bus.i_repeat;
        end else if (beat) begin
            if (index_q == LAST_IDX) begin
                index_q <= '0;
                if (!repeat_q) begin
                    state_q <= ST_IDLE;
                end
            end else begin
                index_q <= index_q + 1'b1;
            end
        end
    end

    // Word capture registers, one per slot of the packed input.
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                words_q[gi] <= '0;
            end else if (load_acc) begin
                words_q[gi] <= bus.i_data[gi*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_piso_stream.sv
// -----------------------------------------------------------------------------
// tb_piso_stream
// Directed self-checking bench for piso_stream (DATA_WIDTH=32, NUM_WORDS=3).
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at that same point, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_piso_stream;
    localparam int DW = 32;
    localparam int NW = 3;
    localparam int IW = $clog2(NW);

    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    piso_stream_if #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) bus ();

    piso_stream #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    localparam logic [DW*NW-1:0] SET_A = {32'h33, 32'h22, 32'h11};
    localparam logic [DW*NW-1:0] SET_B = {32'h66, 32'h55, 32'h44};
    localparam logic [DW*NW-1:0] SET_X = {32'h99999999, 32'h99999999, 32'h99999999};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compares the full output state {valid, index, data, last} in one go.
    task automatic expect_out(input string name, input logic ev, input logic [IW-1:0] ei,
                              input logic [DW-1:0] ed, input logic el);
        // Intentionally inlined per-call comparison of the visible outputs.
        vectors++;
        if ({bus.o_valid, bus.o_index, bus.o_data, bus.o_last} !== {ev, ei, ed, el}) begin
            miscompares++;
            $display("FAIL %s: got v=%0b idx=%0d data=%h last=%0b, expected v=%0b idx=%0d data=%h last=%0b",
                     name, bus.o_valid, bus.o_index, bus.o_data, bus.o_last, ev, ei, ed, el);
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.i_load   = 1'b0;
        bus.i_repeat = 1'b0;
        bus.i_data   = '0;
        bus.i_ready  = 1'b1;
        step();
        step();
        rst = 1'b0;
        expect_out("reset_state", 1'b0, 2'd0, 32'h0, 1'b0);
        vectors++;
        if (bus.o_load_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_load_ready: got %0b expected 1", bus.o_load_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_oneshot();
        bus.i_data   = SET_A;
        bus.i_repeat = 1'b0;
        bus.i_ready  = 1'b1;
        bus.i_load   = 1'b1;
        step();
        bus.i_load = 1'b0;
        expect_out("oneshot_w0", 1'b1, 2'd0, 32'h11, 1'b0);
        step();
        expect_out("oneshot_w1", 1'b1, 2'd1, 32'h22, 1'b0);
        step();
        expect_out("oneshot_w2", 1'b1, 2'd2, 32'h33, 1'b1);
        step();
        expect_out("oneshot_idle", 1'b0, 2'd0, 32'h11, 1'b0);
        $display("test_oneshot done");
    endtask

    task automatic test_backpressure();
        bus.i_data  = SET_A;
        bus.i_ready = 1'b1;
        bus.i_load  = 1'b1;
        step();
        bus.i_load = 1'b0;
        expect_out("bp_w0", 1'b1, 2'd0, 32'h11, 1'b0);
        step();
        bus.i_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            expect_out("bp_stall", 1'b1, 2'd1, 32'h22, 1'b0);
            vectors++;
            if (bus.o_load_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_load_ready[%0d]: got %0b expected 0", k, bus.o_load_ready);
            end
            step();
        end
        bus.i_ready = 1'b1;
        expect_out("bp_release", 1'b1, 2'd1, 32'h22, 1'b0);
        step();
        expect_out("bp_w2", 1'b1, 2'd2, 32'h33, 1'b1);
        step();
        expect_out("bp_idle", 1'b0, 2'd0, 32'h11, 1'b0);
        $display("test_backpressure done");
    endtask

    task automatic test_ignored_load();
        bus.i_data   = SET_A;
        bus.i_repeat = 1'b0;
        bus.i_ready  = 1'b1;
        bus.i_load   = 1'b1;
        step();
        bus.i_load = 1'b0;
        step();
        bus.i_ready = 1'b0;
        bus.i_data  = SET_X;
        bus.i_load  = 1'b1;
        vectors++;
        if (bus.o_load_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ign_load_ready: got %0b expected 0", bus.o_load_ready);
        end
        step();
        bus.i_load = 1'b0;
        expect_out("ign_hold", 1'b1, 2'd1, 32'h22, 1'b0);
        bus.i_ready = 1'b1;
        step();
        expect_out("ign_w2", 1'b1, 2'd2, 32'h33, 1'b1);
        step();
        expect_out("ign_idle", 1'b0, 2'd0, 32'h11, 1'b0);
        $display("test_ignored_load done");
    endtask

    task automatic test_back_to_back();
        bus.i_data   = SET_A;
        bus.i_repeat = 1'b0;
        bus.i_ready  = 1'b1;
        bus.i_load   = 1'b1;
        step();
        bus.i_load = 1'b0;
        expect_out("b2b_w0", 1'b1, 2'd0, 32'h11, 1'b0);
        step();
        expect_out("b2b_w1", 1'b1, 2'd1, 32'h22, 1'b0);
        step();
        expect_out("b2b_w2", 1'b1, 2'd2, 32'h33, 1'b1);
        bus.i_data = SET_B;
        bus.i_load = 1'b1;
        vectors++;
        if (bus.o_load_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_load_ready: got %0b expected 1", bus.o_load_ready);
        end
        step();
        bus.i_load = 1'b0;
        expect_out("b2b_w3", 1'b1, 2'd0, 32'h44, 1'b0);
        step();
        expect_out("b2b_w4", 1'b1, 2'd1, 32'h55, 1'b0);
        step();
        expect_out("b2b_w5", 1'b1, 2'd2, 32'h66, 1'b1);
        step();
        expect_out("b2b_idle", 1'b0, 2'd0, 32'h44, 1'b0);
        $display("test_back_to_back done");
    endtask

    task automatic test_repeat();
        logic [DW-1:0] exp_a [NW];
        logic [IW-1:0] ei;
        exp_a = '{32'h11, 32'h22, 32'h33};
        bus.i_data   = SET_A;
        bus.i_repeat = 1'b1;
        bus.i_ready  = 1'b1;
        bus.i_load   = 1'b1;
        step();
        bus.i_load = 1'b0;
        for (int k = 0; k < 10; k++) begin
            ei = IW'(k % NW);
            expect_out("rep_rot", 1'b1, ei, exp_a[k % NW], (k % NW) == NW - 1);
            vectors++;
            if (bus.o_load_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL rep_load_ready[%0d]: got %0b expected 1", k, bus.o_load_ready);
            end
            step();
        end
        expect_out("rep_pre_load", 1'b1, 2'd1, 32'h22, 1'b0);
        bus.i_data = SET_B;
        bus.i_load = 1'b1;
        step();
        bus.i_load = 1'b0;
        expect_out("rep_new_w0", 1'b1, 2'd0, 32'h44, 1'b0);
        step();
        expect_out("rep_new_w1", 1'b1, 2'd1, 32'h55, 1'b0);
        step();
        expect_out("rep_new_w2", 1'b1, 2'd2, 32'h66, 1'b1);
        step();
        expect_out("rep_new_wrap", 1'b1, 2'd0, 32'h44, 1'b0);
        $display("test_repeat done");
    endtask

    task automatic test_reset_mid();
        bus.i_data   = SET_A;
        bus.i_repeat = 1'b0;
        bus.i_ready  = 1'b1;
        bus.i_load   = 1'b1;
        step();
        bus.i_load = 1'b0;
        step();
        expect_out("rstmid_w1", 1'b1, 2'd1, 32'h22, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_out("rstmid_cleared", 1'b0, 2'd0, 32'h0, 1'b0);
        bus.i_data = SET_B;
        bus.i_load = 1'b1;
        step();
        bus.i_load = 1'b0;
        expect_out("rstmid_w0", 1'b1, 2'd0, 32'h44, 1'b0);
        step();
        expect_out("rstmid_next1", 1'b1, 2'd1, 32'h55, 1'b0);
        step();
        expect_out("rstmid_next2", 1'b1, 2'd2, 32'h66, 1'b1);
        step();
        expect_out("rstmid_idle", 1'b0, 2'd0, 32'h44, 1'b0);
        $display("test_reset_mid done");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        test_reset();
        test_oneshot();
        test_backpressure();
        test_ignored_load();
        test_back_to_back();
        test_repeat();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
